// File: rtl/cond_eval_unit.sv
// cond_eval_unit: ARM condition evaluator with architectural flag register and in-flight flag-write scoreboard.
// Optional COND_FLAG_FWD_EN: evaluate straight from the committing ALU flag vector when it is the last outstanding write.
module cond_eval_unit #(
    parameter int         PENDING_MAX = 3,
    parameter logic [7:0] RESET_FLAGS = 8'h00,
    localparam int        CW          = $clog2(PENDING_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flag_issue,
    output logic          issue_ready,
    input  logic          flag_wr_en,
    input  logic [7:0]    flag_wr_data,
    input  logic          cond_valid,
    input  logic [3:0]    cond_code,
    output logic          cond_ready,
    output logic          res_valid,
    output logic          res_pass,
    output logic          res_err,
    input  logic          res_ready,
    input  logic          flush,
    output logic [7:0]    flags_q,
    output logic [CW-1:0] pending_cnt,
    output logic          underflow_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [3:0]    code_q, code_nx, eval_code;
    logic [CW-1:0] cnt_nx;
    logic          fwd, ld_res, pass_nx, err_nx;

    // Result is {pass, err}; carry-based codes and NV cannot be evaluated on this flag set
    function automatic logic [1:0] cond_eval(input logic [3:0] c, input logic [7:0] f);
        case (c)
            4'b0000: return {f[6], 1'b0};
            4'b0001: return {!f[6], 1'b0};
            4'b0100: return {f[7], 1'b0};
            4'b0101: return {!f[7], 1'b0};
            4'b0110: return {f[4], 1'b0};
            4'b0111: return {!f[4], 1'b0};
            4'b1010: return {f[3], 1'b0};
            4'b1011: return {f[2], 1'b0};
            4'b1100: return {f[1], 1'b0};
            4'b1101: return {f[0], 1'b0};
            4'b1110: return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    assign issue_ready = (pending_cnt < CW'(PENDING_MAX)) || flag_wr_en;
    assign cond_ready  = (state == IDLE);
    assign res_valid   = (state == RESP);

`ifdef COND_FLAG_FWD_EN
    assign fwd = (pending_cnt == CW'(1)) && flag_wr_en && !flag_issue;
`else
    assign fwd = 1'b0;
`endif

    assign {pass_nx, err_nx} = cond_eval(eval_code, fwd ? flag_wr_data : flags_q);

    // Scoreboard next value: a same-cycle issue and commit cancel out
    always_comb begin
        cnt_nx = pending_cnt;
        if (flag_issue && !flag_wr_en && issue_ready)
            cnt_nx = pending_cnt + 1'b1;
        else if (flag_wr_en && !flag_issue && pending_cnt != '0)
            cnt_nx = pending_cnt - 1'b1;
    end

    // Flag register, in-flight counter and sticky underflow indicator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q       <= RESET_FLAGS;
            pending_cnt   <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (flag_wr_en)
                flags_q <= flag_wr_data;
            if (flag_wr_en && pending_cnt == '0)
                underflow_err <= 1'b1;
            pending_cnt <= cnt_nx;
        end
    end

    // Request FSM next state; an issue in the accept cycle counts as older, and flush wins over everything
    always_comb begin
        state_nx  = state;
        code_nx   = code_q;
        eval_code = code_q;
        ld_res    = 1'b0;
        case (state)
            IDLE: if (cond_valid) begin
                eval_code = cond_code;
                code_nx   = cond_code;
                if (fwd || (pending_cnt == '0 && !flag_issue)) begin
                    state_nx = RESP;
                    ld_res   = 1'b1;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: if (fwd || pending_cnt == '0) begin
                state_nx = RESP;
                ld_res   = 1'b1;
            end
            RESP: if (res_ready)
                state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx = IDLE;
            ld_res   = 1'b0;
        end
    end

    // Request FSM state, latched condition and registered result held stable through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            code_q   <= '0;
            res_pass <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            state  <= state_nx;
            code_q <= code_nx;
            if (ld_res) begin
                res_pass <= pass_nx;
                res_err  <= err_nx;
            end
        end
    end
endmodule

// File: tb/tb_cond_eval_unit.sv
// tb_cond_eval_unit: directed and random checks of cond_eval_unit against a request-level reference model.
module tb_cond_eval_unit;
    localparam int         PMAX  = 3;
    localparam logic [7:0] RST_F = 8'h00;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       flag_issue = 1'b0, flag_wr_en = 1'b0, cond_valid = 1'b0, res_ready = 1'b0, flush = 1'b0;
    logic [7:0] flag_wr_data = 8'h00;
    logic [3:0] cond_code = 4'h0;
    logic       issue_ready, cond_ready, res_valid, res_pass, res_err, underflow_err;
    logic [7:0] flags_q;
    logic [1:0] pending_cnt;

    int n_chk = 0, n_ok = 0;

    logic [7:0] m_flags;
    int         m_pend;
    bit         m_uf, m_req, m_done, m_pass, m_err;
    logic [3:0] m_code;

    cond_eval_unit #(.PENDING_MAX(PMAX), .RESET_FLAGS(RST_F)) dut (
        .clk(clk), .rst_n(rst_n), .flag_issue(flag_issue), .issue_ready(issue_ready),
        .flag_wr_en(flag_wr_en), .flag_wr_data(flag_wr_data), .cond_valid(cond_valid),
        .cond_code(cond_code), .cond_ready(cond_ready), .res_valid(res_valid),
        .res_pass(res_pass), .res_err(res_err), .res_ready(res_ready), .flush(flush),
        .flags_q(flags_q), .pending_cnt(pending_cnt), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_ok++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Flag bit selected by each condition; -1 means not evaluable, 8 means always
    function automatic logic [1:0] ref_eval(input logic [3:0] c, input logic [7:0] f);
        int sel[16];
        bit inv;
        sel = '{6, 6, -1, -1, 7, 7, 4, 4, -1, -1, 3, 2, 1, 0, 8, -1};
        inv = (c < 4'd8) && c[0];
        if (sel[c] < 0) return 2'b01;
        if (sel[c] == 8) return 2'b10;
        return {f[sel[c]] ^ inv, 1'b0};
    endfunction

    task automatic model_reset();
        m_flags = RST_F; m_pend = 0; m_uf = 0; m_req = 0; m_done = 0; m_pass = 0; m_err = 0; m_code = 0;
    endtask

    task automatic resolve(input bit fwd);
        logic [1:0] r;
        r = ref_eval(m_code, fwd ? flag_wr_data : m_flags);
        m_pass = r[1]; m_err = r[0]; m_done = 1;
    endtask

    task automatic model_step();
        bit fwd;
        fwd = (m_pend == 1) && flag_wr_en && !flag_issue;
`ifndef COND_FLAG_FWD_EN
        fwd = 0;
`endif
        if (flush) begin
            m_req = 0; m_done = 0;
        end else if (!m_req) begin
            if (cond_valid) begin
                m_req = 1; m_done = 0; m_code = cond_code;
                if (fwd || (m_pend == 0 && !flag_issue)) resolve(fwd);
            end
        end else if (!m_done) begin
            if (fwd || m_pend == 0) resolve(fwd);
        end else if (res_ready) begin
            m_req = 0; m_done = 0;
        end
        if (flag_wr_en && m_pend == 0) m_uf = 1;
        if (flag_issue && !flag_wr_en && m_pend < PMAX) m_pend++;
        else if (flag_wr_en && !flag_issue && m_pend > 0) m_pend--;
        if (flag_wr_en) m_flags = flag_wr_data;
    endtask

    task automatic check_all();
        chk("flags_q", flags_q, m_flags);
        chk("pending_cnt", pending_cnt, m_pend);
        chk("underflow_err", underflow_err, m_uf);
        chk("res_valid", res_valid, m_req && m_done);
        chk("cond_ready", cond_ready, !m_req);
        if (m_req && m_done) begin
            chk("res_pass", res_pass, m_pass);
            chk("res_err", res_err, m_err);
        end
    endtask

    task automatic drive(input bit fi, input bit fw, input logic [7:0] fd, input bit cv,
                         input logic [3:0] cc, input bit rr, input bit fl);
        flag_issue = fi; flag_wr_en = fw; flag_wr_data = fd; cond_valid = cv;
        cond_code = cc; res_ready = rr; flush = fl;
    endtask

    task automatic tick();
        #1;
        chk("issue_ready", issue_ready, (m_pend < PMAX) || flag_wr_en);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst.res_valid", res_valid, 0);
        chk("rst.flags_q", flags_q, RST_F);
        chk("rst.pending", pending_cnt, 0);
        chk("rst.uf", underflow_err, 0);
        chk("rst.cond_ready", cond_ready, 1);
        chk("rst.issue_ready", issue_ready, 1);
        chk("rst.res_pass", res_pass, 0);
        chk("rst.res_err", res_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Z set by an unscoreboarded write, then EQ and NE
        drive(0, 1, 8'h40, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 4'b0000, 0, 0); tick();
        chk("eq.valid", res_valid, 1);
        chk("eq.pass", res_pass, 1);
        chk("eq.err", res_err, 0);
        drive(0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 1, 4'b0001, 0, 0); tick();
        chk("ne.pass", res_pass, 0);
        drive(0, 0, 0, 0, 0, 1, 0); tick();

        // Two in flight, GT waits for both commits
        drive(1, 0, 0, 0, 0, 0, 0); tick(); tick();
        chk("two.pending", pending_cnt, 2);
        drive(0, 0, 0, 1, 4'b1100, 0, 0); tick();
        chk("wait.cond_ready", cond_ready, 0);
        drive(0, 1, 8'h00, 0, 0, 0, 0); tick();
        chk("wait.no_res", res_valid, 0);
        drive(0, 1, 8'h02, 0, 0, 0, 0); tick();
`ifdef COND_FLAG_FWD_EN
        chk("gt.fwd_valid", res_valid, 1);
`else
        chk("gt.nofwd_valid", res_valid, 0);
`endif
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        chk("gt.valid", res_valid, 1);
        chk("gt.pass", res_pass, 1);
        drive(0, 0, 0, 0, 0, 1, 0); tick();

        // Fill the scoreboard, simultaneous issue+commit, then drain and underflow
        drive(1, 0, 0, 0, 0, 0, 0); tick(); tick(); tick();
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        chk("full.issue_ready", issue_ready, 0);
        drive(1, 1, 8'h11, 0, 0, 0, 0); #1;
        chk("full.sim_issue_ready", issue_ready, 1);
        tick();
        chk("full.sim_pending", pending_cnt, 3);
        drive(0, 1, 8'h22, 0, 0, 0, 0); tick(); tick(); tick();
        chk("drain.pending", pending_cnt, 0);
        tick();
        chk("uf.set", underflow_err, 1);
        chk("uf.pending", pending_cnt, 0);

        // Unevaluable codes and AL
        drive(0, 0, 0, 1, 4'b0010, 0, 0); tick();
        chk("cs.pass", res_pass, 0);
        chk("cs.err", res_err, 1);
        drive(0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 1, 4'b1111, 0, 0); tick();
        chk("nv.err", res_err, 1);
        drive(0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 1, 4'b1110, 0, 0); tick();
        chk("al.pass", res_pass, 1);
        chk("al.err", res_err, 0);

        // Back-pressure holds the result
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("hold.valid", res_valid, 1);
        chk("hold.pass", res_pass, 1);
        drive(0, 0, 0, 0, 0, 1, 0); tick();
        chk("hold.release_valid", res_valid, 0);
        chk("hold.release_ready", cond_ready, 1);

        // Flush in WAIT
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 4'b0000, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        chk("flush.valid", res_valid, 0);
        chk("flush.cond_ready", cond_ready, 1);
        chk("flush.pending", pending_cnt, 1);
        drive(0, 1, 8'h80, 0, 0, 0, 0); tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(9) < 3, $urandom_range(9) < 3, 8'($urandom), $urandom_range(9) < 4,
                  4'($urandom_range(15)), $urandom_range(9) < 6, $urandom_range(19) == 0);
            tick();
        end

        // Asynchronous reset while a result is pending
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        for (int i = 0; i < 8 && m_pend > 0; i++) begin
            drive(0, 1, 8'h5A, 0, 0, 0, 0); tick();
        end
        drive(0, 1, 8'h5A, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 4'b1110, 0, 0); tick();
        chk("ar.pre_valid", res_valid, 1);
        chk("ar.pre_flags", flags_q, 8'h5A);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar.res_valid", res_valid, 0);
        chk("ar.flags_q", flags_q, RST_F);
        chk("ar.pending", pending_cnt, 0);
        chk("ar.uf", underflow_err, 0);
        chk("ar.cond_ready", cond_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
